pc_sel_reg: RTL and testbench
=============================

PC_SEL_REG -- requirements
Module: pc_sel_reg

Interface
REQ-001 Parameter WIDTH, default 32, is the PC and source datapath width in bits.
REQ-002 Parameter NSRC, default 6, is the number of next-PC source channels (2..8).
REQ-003 Parameter SELW, default 3, is the select width; it SHALL satisfy 2**SELW >= NSRC.
REQ-004 Parameter RESET_PC, default 0, is the PC value loaded on reset.
REQ-005 Parameter EXC_VEC, default 32'h000000FF, is the exception entry address.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 src  in  NSRC*WIDTH  packed sources; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 sel  in  SELW  source select.
REQ-010 pc_write  in  1  unconditional PC load request.
REQ-011 pc_write_cond  in  1  conditional PC load request, qualified by cond.
REQ-012 cond  in  1  branch condition.
REQ-013 exc_req  in  1  external exception request, level-sampled each cycle.
REQ-014 eret  in  1  return-from-exception request.
REQ-015 pc  out  WIDTH  registered program counter.
REQ-016 epc  out  WIDTH  registered exception PC.
REQ-017 in_exc  out  1  high while the FSM is in state EXC.
REQ-018 cause  out  2  registered cause: 00 none, 01 external, 10 misaligned.
REQ-019 pc_changed  out  1  one-cycle pulse, registered, asserted the cycle after any PC load.

Function
REQ-020 Candidate target = src channel sel when sel < NSRC, otherwise channel NSRC-1 (fall-through to the last channel).
REQ-021 Normal load (ld) = pc_write | (pc_write_cond & cond); on ld, pc <= candidate at the next edge, with 1-cycle latency.
REQ-022 FSM states: IDLE, EXC; reset state is IDLE.
REQ-023 IDLE with exc_req=1: epc <= pc, pc <= EXC_VEC, cause <= 01, state -> EXC; ld in the same cycle is discarded.
REQ-024 EXC with eret=1: pc <= epc, cause <= 00, state -> IDLE; ld in the same cycle is discarded.
REQ-025 EXC with exc_req=1: the request is ignored (no nesting); epc and cause hold.
REQ-026 IDLE with eret=1 and exc_req=0: eret is ignored; ld proceeds normally.
REQ-027 Priority within a cycle: exc_req (IDLE) > eret (EXC) > ld.
REQ-028 In EXC, ld without eret loads pc normally; state, epc and cause hold.
REQ-029 If no load occurs, pc, epc and cause hold.
REQ-030 pc_changed SHALL be 1 in the cycle after any pc update, including exception entry and eret; otherwise 0.
REQ-031 Every output SHALL be a register output, with no combinational input-to-output path.

Reset
REQ-032 Asserting reset SHALL immediately force pc=RESET_PC, epc=0, cause=00, in_exc=0, pc_changed=0, state IDLE.
REQ-033 Reset asserted in mid-exception SHALL abandon EXC with no eret required.
REQ-034 The first load SHALL occur at the first rising edge after reset deasserts.

Configuration
REQ-035 Macro PC_ALIGN_CHECK_EN: when defined, an ld in IDLE whose candidate[1:0] != 00 SHALL instead perform exception entry (epc <= pc, pc <= EXC_VEC, cause <= 10, state -> EXC).
REQ-036 When PC_ALIGN_CHECK_EN is defined, a misaligned ld in EXC SHALL load pc unchanged, with no nesting.
REQ-037 Without PC_ALIGN_CHECK_EN, all targets load as-is and cause never takes the value 10.

Verification
REQ-038 Reset: assert reset with RESET_PC=0 -> pc=0, epc=0, in_exc=0, cause=00 immediately, without waiting for a clock edge.
REQ-039 Select sweep: src channel k = 32'h100+4k, sel=0..7, pc_write=1 -> pc=32'h100+4*sel for sel<6, and 32'h114 for sel=6 and sel=7.
REQ-040 Conditional load: pc_write_cond=1 with cond=0 -> pc holds and pc_changed=0; with cond=1 -> pc loads and pc_changed pulses once.
REQ-041 Exception round trip: pc=32'h40, exc_req=1 together with pc_write=1 -> pc=32'hFF, epc=32'h40, cause=01, in_exc=1; a second exc_req leaves epc=32'h40; eret -> pc=32'h40, in_exc=0, cause=00.
REQ-042 Misalignment, with PC_ALIGN_CHECK_EN defined: pc_write with target 32'h102 -> pc=32'hFF, cause=10, epc=previous pc; without the macro -> pc=32'h102.
REQ-043 Reset in EXC: assert reset while in_exc=1 -> in_exc=0, pc=RESET_PC; after release, eret alone does not change pc.

Source files
------------

// File: rtl/pc_sel_reg.sv
// Program counter register with next-PC source select and a two-state exception FSM.
// Optional target alignment trap is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sel_reg #(
    parameter int              WIDTH    = 32,
    parameter int              NSRC     = 6,
    parameter int              SELW     = 3,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC  = 'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [SELW-1:0]       sel,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  cond,
    input  logic                  exc_req,
    input  logic                  eret,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      epc,
    output logic                  in_exc,
    output logic [1:0]            cause,
    output logic                  pc_changed
);

    typedef enum logic {
        IDLE = 1'b0,
        EXC  = 1'b1
    } state_t;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_EXT  = 2'b01;
    localparam logic [1:0] C_MIS  = 2'b10;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] epc_d;
    logic [1:0]       cause_d;
    logic             chg_d;
    logic             ld;
    logic             mis;
    logic             take_exc;
    logic             take_ret;

    assign ld = pc_write | (pc_write_cond & cond);

    // Select the candidate target; out-of-range selects fall through to the last channel
    always_comb begin
        cand = src[(NSRC-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k))
                cand = src[k*WIDTH +: WIDTH];
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign mis = (cand[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Exception entry only from IDLE (no nesting); eret only acts in EXC
    assign take_exc = (state == IDLE) & (exc_req | (ld & mis));
    assign take_ret = (state == EXC) & eret;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state;
        if (take_exc)
            state_d = EXC;
        else if (take_ret)
            state_d = IDLE;
    end

    // Next values of the PC, EPC and cause registers, with exception > eret > ld
    always_comb begin
        pc_d    = pc;
        epc_d   = epc;
        cause_d = cause;
        chg_d   = 1'b0;
        if (take_exc) begin
            epc_d   = pc;
            pc_d    = EXC_VEC;
            cause_d = exc_req ? C_EXT : C_MIS;
            chg_d   = 1'b1;
        end else if (take_ret) begin
            pc_d    = epc;
            cause_d = C_NONE;
            chg_d   = 1'b1;
        end else if (ld) begin
            pc_d    = cand;
            chg_d   = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            epc        <= '0;
            cause      <= C_NONE;
            pc_changed <= 1'b0;
        end else begin
            pc         <= pc_d;
            epc        <= epc_d;
            cause      <= cause_d;
            pc_changed <= chg_d;
        end
    end

    assign in_exc = (state == EXC);

endmodule

// File: tb/tb_pc_sel_reg.sv
// Directed bench for pc_sel_reg with a scoreboard of expected register states.
// Misalignment expectations follow PC_ALIGN_CHECK_EN.
module tb_pc_sel_reg;

    logic           clk;
    logic           reset;
    logic [191:0]   src;
    logic [2:0]     sel;
    logic           pc_write;
    logic           pc_write_cond;
    logic           cond;
    logic           exc_req;
    logic           eret;
    logic [31:0]    pc;
    logic [31:0]    epc;
    logic           in_exc;
    logic [1:0]     cause;
    logic           pc_changed;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        in_exc;
        logic        chg;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    pc_sel_reg dut (
        .clk           (clk),
        .reset         (reset),
        .src           (src),
        .sel           (sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond          (cond),
        .exc_req       (exc_req),
        .eret          (eret),
        .pc            (pc),
        .epc           (epc),
        .in_exc        (in_exc),
        .cause         (cause),
        .pc_changed    (pc_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".epc"}, epc, e.epc);
        chk({tag, ".cause"}, 32'(cause), 32'(e.cause));
        chk({tag, ".in_exc"}, 32'(in_exc), 32'(e.in_exc));
        chk({tag, ".chg"}, 32'(pc_changed), 32'(e.chg));
    endtask

    task automatic set_src_default();
        for (int k = 0; k < 6; k++)
            src[k*32 +: 32] = 32'h100 + 32'(4 * k);
    endtask

    // Drive one cycle of inputs, queue the expected state, clock, then pop and compare
    task automatic step(input string tag, input logic [2:0] s,
                        input logic w, input logic wc, input logic c,
                        input logic x, input logic r,
                        input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic [1:0] e_cause, input logic e_exc,
                        input logic e_chg);
        exp_t e;
        exp_t got;
        string t;
        sel           = s;
        pc_write      = w;
        pc_write_cond = wc;
        cond          = c;
        exc_req       = x;
        eret          = r;
        e.pc     = e_pc;
        e.epc    = e_epc;
        e.cause  = e_cause;
        e.in_exc = e_exc;
        e.chg    = e_chg;
        sb.push_back(e);
        tags.push_back(tag);
        @(posedge clk);
        #1;
        sel           = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        cond          = 1'b0;
        exc_req       = 1'b0;
        eret          = 1'b0;
        got = sb.pop_front();
        t   = tags.pop_front();
        chk_all(t, got);
    endtask

    initial begin
        exp_t r0;
        reset         = 1'b0;
        sel           = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        cond          = 1'b0;
        exc_req       = 1'b0;
        eret          = 1'b0;
        src           = '0;
        set_src_default();

        // Asynchronous reset, observed before any clock edge
        #2 reset = 1'b1;
        #1;
        r0.pc = 32'h0; r0.epc = 32'h0; r0.cause = 2'b00;
        r0.in_exc = 1'b0; r0.chg = 1'b0;
        chk_all("rst_async", r0);
        @(posedge clk);
        #1 reset = 1'b0;

        // First load at first edge after release
        step("first_ld", 3'd2, 1, 0, 0, 0, 0, 32'h108, 0, 2'b00, 0, 1);

        // Select sweep including out-of-range fall-through
        for (int i = 0; i < 8; i++) begin
            logic [31:0] e;
            e = (i < 6) ? 32'h100 + 32'(4 * i) : 32'h114;
            step($sformatf("sweep%0d", i), 3'(i), 1, 0, 0, 0, 0,
                 e, 0, 2'b00, 0, 1);
        end

        // Conditional load
        step("cond0", 3'd0, 0, 1, 0, 0, 0, 32'h114, 0, 2'b00, 0, 0);
        step("cond1", 3'd0, 0, 1, 1, 0, 0, 32'h100, 0, 2'b00, 0, 1);
        step("cond_idle", 3'd0, 0, 0, 0, 0, 0, 32'h100, 0, 2'b00, 0, 0);

        // Exception round trip from pc=0x40
        src[1*32 +: 32] = 32'h40;
        step("to_40", 3'd1, 1, 0, 0, 0, 0, 32'h40, 0, 2'b00, 0, 1);
        set_src_default();
        step("exc_in", 3'd0, 1, 0, 0, 1, 0, 32'hFF, 32'h40, 2'b01, 1, 1);
        step("exc_nest", 3'd0, 0, 0, 0, 1, 0, 32'hFF, 32'h40, 2'b01, 1, 0);
        step("exc_ld", 3'd0, 1, 0, 0, 0, 0, 32'h100, 32'h40, 2'b01, 1, 1);
        step("eret", 3'd2, 1, 0, 0, 0, 1, 32'h40, 32'h40, 2'b00, 0, 1);
        step("post_eret", 3'd0, 0, 0, 0, 0, 0, 32'h40, 32'h40, 2'b00, 0, 0);

        // eret in IDLE is ignored, load proceeds
        step("idle_eret", 3'd2, 1, 0, 0, 0, 1, 32'h108, 32'h40, 2'b00, 0, 1);

        // Misaligned target
        src[0 +: 32] = 32'h102;
`ifdef PC_ALIGN_CHECK_EN
        step("mis_idle", 3'd0, 1, 0, 0, 0, 0, 32'hFF, 32'h108, 2'b10, 1, 1);
        step("mis_exc", 3'd0, 1, 0, 0, 0, 0, 32'h102, 32'h108, 2'b10, 1, 1);
`else
        step("mis_idle", 3'd0, 1, 0, 0, 0, 0, 32'h102, 32'h40, 2'b00, 0, 1);
        step("exc_again", 3'd0, 0, 0, 0, 1, 0, 32'hFF, 32'h102, 2'b01, 1, 1);
`endif
        set_src_default();

        // Reset while in EXC abandons the exception immediately
        chk("pre_rst_exc", 32'(in_exc), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all("rst_exc", r0);
        @(posedge clk);
        #1 reset = 1'b0;
        step("eret_after_rst", 3'd0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 2'b00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
